// File: rtl/reg_bank_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_bank_if : write/increment/clear/read bundle between a host and reg_bank
// Revision    : 1.0
// ----------------------------------------------------------------------------
interface reg_bank_if #(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 4
);
   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic             wr_valid;
   logic             wr_ready;
   logic [AW-1:0]    wr_addr;
   logic [7:0]       wr_byte;
   logic             wr_done;
   logic             wr_err;
   logic             inc_valid;
   logic [AW-1:0]    inc_addr;
   logic             inc_drop;
   logic             clr_all;
   logic [AW-1:0]    rd_addr_a;
   logic [WIDTH-1:0] rd_data_a;
   logic [AW-1:0]    rd_addr_b;
   logic [WIDTH-1:0] rd_data_b;

   modport master (
      output wr_valid, wr_addr, wr_byte, inc_valid, inc_addr, clr_all,
             rd_addr_a, rd_addr_b,
      input  wr_ready, wr_done, wr_err, inc_drop, rd_data_a, rd_data_b
   );

   modport slave (
      input  wr_valid, wr_addr, wr_byte, inc_valid, inc_addr, clr_all,
             rd_addr_a, rd_addr_b,
      output wr_ready, wr_done, wr_err, inc_drop, rd_data_a, rd_data_b
   );
endinterface
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_bank : NUM_REGS x WIDTH registers, byte-serial atomic writes, increment,
//            global clear and two registered read ports
// Revision : 1.0
// ----------------------------------------------------------------------------
module reg_bank #(
   parameter int               WIDTH     = 8,
   parameter int               NUM_REGS  = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic       clk,
   input  logic       rst,
   reg_bank_if.slave  bus
);
   localparam int BEATS = WIDTH / 8;
   localparam int AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CW    = $clog2(BEATS) + 1;
   localparam logic [AW:0]    c_NUM_REGS = (AW+1)'(NUM_REGS);
   localparam logic [CW-1:0]  c_LAST     = CW'(BEATS - 1);
   localparam logic [WIDTH-1:0] c_ONE    = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_regs [NUM_REGS];
   logic [WIDTH-1:0] r_buf;
   logic [AW-1:0]    r_addr;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rd_a;
   logic [WIDTH-1:0] r_rd_b;

   logic             w_ready;
   logic             w_accept;
   logic [CW-1:0]    w_beat;
   logic             w_last;
   logic             w_commit;
   logic             w_commit_ok;
   logic             w_done;
   logic             w_err;
   logic             w_inc_ok;
   logic             w_drop;
   logic             w_addr_ok;
   logic             w_inc_in_range;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;

   assign w_addr_ok      = ({1'b0, r_addr} < c_NUM_REGS);
   assign w_inc_in_range = ({1'b0, bus.inc_addr} < c_NUM_REGS);
   assign w_accept       = bus.wr_valid & w_ready;
   // First beat always lands in byte 0, so the counter need not be cleared between writes
   assign w_beat         = (r_state == S_IDLE) ? '0 : r_cnt;
   assign w_last         = (w_beat == c_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (w_accept) begin
               w_state_nxt = (BEATS == 1) ? S_COMMIT : S_COLLECT;
            end
         end
         S_COLLECT: begin
            w_ready = 1'b1;
            if (w_accept && w_last) begin
               w_state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (rst || bus.clr_all) begin
         w_ready     = 1'b0;
         w_commit    = 1'b0;
         w_state_nxt = S_IDLE;
      end
      w_accept_unused_guard();
   end

   function automatic void w_accept_unused_guard();
   endfunction

   assign w_commit_ok = w_commit & w_addr_ok;
   assign w_done      = w_commit_ok;
   assign w_err       = w_commit & ~w_addr_ok;
   assign w_drop      = w_commit_ok & bus.inc_valid & (bus.inc_addr == r_addr);
   assign w_inc_ok    = bus.inc_valid & w_inc_in_range & ~w_drop & ~rst & ~bus.clr_all;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf  <= '0;
         r_addr <= '0;
         r_cnt  <= '0;
      end else if (bus.clr_all) begin
         r_cnt  <= '0;
      end else if (w_accept) begin
         if (r_state == S_IDLE) begin
            r_addr <= bus.wr_addr;
         end
         for (int b = 0; b < BEATS; b++) begin
            if (w_beat == CW'(b)) begin
               r_buf[8*b +: 8] <= bus.wr_byte;
            end
         end
         r_cnt <= w_beat + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rst || bus.clr_all) begin
            r_regs[i] <= RESET_VAL;
         end else if (w_commit_ok && (r_addr == AW'(i))) begin
            r_regs[i] <= r_buf;
         end else if (w_inc_ok && (bus.inc_addr == AW'(i))) begin
            r_regs[i] <= r_regs[i] + c_ONE;
         end
      end
   end

   // Decoding by compare keeps out-of-range addresses at zero without indexing past the array
   always_comb begin
      w_rd_a = '0;
      w_rd_b = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.rd_addr_a == AW'(i)) begin
            w_rd_a = r_regs[i];
         end
         if (bus.rd_addr_b == AW'(i)) begin
            w_rd_b = r_regs[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_a <= '0;
         r_rd_b <= '0;
      end else begin
         r_rd_a <= w_rd_a;
         r_rd_b <= w_rd_b;
      end
   end

   assign bus.wr_ready  = w_ready;
   assign bus.wr_done   = w_done;
   assign bus.wr_err    = w_err;
   assign bus.inc_drop  = w_drop;
   assign bus.rd_data_a = r_rd_a;
   assign bus.rd_data_b = r_rd_b;
endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reg_bank : table, directed and randomized checks of reg_bank (16-bit, 3 regs)
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_reg_bank;
   localparam int          W     = 16;
   localparam int          N     = 3;
   localparam int          AW    = 2;
   localparam int          BEATS = W / 8;
   localparam logic [W-1:0] RV   = 16'h5A01;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   reg_bank_if #(.WIDTH(W), .NUM_REGS(N)) bus ();

   reg_bank #(.WIDTH(W), .NUM_REGS(N), .RESET_VAL(RV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference: register contents, pending bytes of the write in flight and its target
   logic [W-1:0] m [N];
   logic [7:0]   q [$];
   int           tgt;
   logic [W-1:0] exp_ra, exp_rb;
   logic         obs_ready, obs_done, obs_err, obs_drop;

   typedef struct {
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
      logic          exp_done;
      logic          exp_err;
      logic [W-1:0]  exp_rd;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m[i] = RV;
      q.delete();
      tgt    = 0;
      exp_ra = '0;
      exp_rb = '0;
   endtask

   // One clock: check outputs against the reference mid-cycle, then advance it
   task automatic cycle();
      logic         commit, e_rdy;
      logic [W-1:0] nra, nrb, asm;
      int           ia;
      @(negedge clk);
      commit = (q.size() == BEATS);
      e_rdy  = !rst && !bus.clr_all && !commit;
      ia     = int'(bus.inc_addr);
      obs_ready = bus.wr_ready;
      obs_done  = bus.wr_done;
      obs_err   = bus.wr_err;
      obs_drop  = bus.inc_drop;
      chk("wr_ready", obs_ready, e_rdy);
      chk("wr_done", obs_done, !rst && !bus.clr_all && commit && tgt < N);
      chk("wr_err", obs_err, !rst && !bus.clr_all && commit && tgt >= N);
      chk("inc_drop", obs_drop, !rst && !bus.clr_all && commit && tgt < N &&
          bus.inc_valid && ia == tgt);
      chk("rd_data_a", bus.rd_data_a, exp_ra);
      chk("rd_data_b", bus.rd_data_b, exp_rb);
      nra = (int'(bus.rd_addr_a) < N) ? m[bus.rd_addr_a] : '0;
      nrb = (int'(bus.rd_addr_b) < N) ? m[bus.rd_addr_b] : '0;
      if (rst) begin
         model_reset();
      end else begin
         if (bus.clr_all) begin
            for (int i = 0; i < N; i++) m[i] = RV;
            q.delete();
         end else begin
            if (commit) begin
               asm = '0;
               for (int k = 0; k < BEATS; k++) asm = asm | (W'(q[k]) << (8 * k));
               if (tgt < N) m[tgt] = asm;
               q.delete();
            end
            if (bus.inc_valid && ia < N && !(commit && tgt < N && ia == tgt))
               m[ia] = m[ia] + 1'b1;
            if (bus.wr_valid && e_rdy) begin
               if (q.size() == 0) tgt = int'(bus.wr_addr);
               q.push_back(bus.wr_byte);
            end
         end
         exp_ra = nra;
         exp_rb = nrb;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d,
                     input logic iv, input logic [AW-1:0] ia);
      for (int b = 0; b < BEATS; b++) begin
         int g = 0;
         bus.wr_valid = 1'b1;
         bus.wr_addr  = a;
         bus.wr_byte  = d[8*b +: 8];
         do begin
            cycle();
            g++;
         end while (!obs_ready && g < 8);
         if (!obs_ready) chk("wr_accept_timeout", obs_ready, 1'b1);
      end
      bus.wr_valid  = 1'b0;
      bus.inc_valid = iv;
      bus.inc_addr  = ia;
      cycle();
      bus.inc_valid = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
      bus.rd_addr_a = a;
      bus.rd_addr_b = b;
      cycle();
   endtask

   initial begin
      tbl[0] = '{2'd0, 16'h1234, 1'b1, 1'b0, 16'h1234};
      tbl[1] = '{2'd1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
      tbl[2] = '{2'd2, 16'h00AA, 1'b1, 1'b0, 16'h00AA};
      tbl[3] = '{2'd3, 16'hBEEF, 1'b0, 1'b1, 16'h0000};
      tbl[4] = '{2'd2, 16'hA55A, 1'b1, 1'b0, 16'hA55A};
      tbl[5] = '{2'd0, 16'h8001, 1'b1, 1'b0, 16'h8001};

      rst = 1'b1;
      bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_byte = '0;
      bus.inc_valid = 1'b0; bus.inc_addr = '0; bus.clr_all = 1'b0;
      bus.rd_addr_a = '0; bus.rd_addr_b = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      cycle();
      chk("ready_after_rst", obs_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         rd(AW'(i), AW'(3 - i));
         chk("rst_rd_a", bus.rd_data_a, (i < N) ? RV : 16'h0);
         chk("rst_rd_b", bus.rd_data_b, (3 - i < N) ? RV : 16'h0);
      end

      // Write table: commit status pulse, then both ports read the target back
      for (int v = 0; v < 6; v++) begin
         wr(tbl[v].addr, tbl[v].data, 1'b0, '0);
         chk("tbl_done", obs_done, tbl[v].exp_done);
         chk("tbl_err", obs_err, tbl[v].exp_err);
         rd(tbl[v].addr, tbl[v].addr);
         chk("tbl_rd_a", bus.rd_data_a, tbl[v].exp_rd);
         chk("tbl_rd_b", bus.rd_data_b, tbl[v].exp_rd);
      end

      // wr_done lands in the third cycle of a two-beat write
      bus.wr_valid = 1'b1; bus.wr_addr = 2'd2; bus.wr_byte = 8'h34;
      cycle();
      bus.wr_addr = 2'd0; bus.wr_byte = 8'h12;
      cycle();
      chk("beat2_no_done", obs_done, 1'b0);
      bus.wr_valid = 1'b0;
      cycle();
      chk("cycle3_done", obs_done, 1'b1);
      rd(2'd2, 2'd2);
      chk("two_beat_rd", bus.rd_data_a, 16'h1234);

      // Increment wrap and count
      wr(2'd1, 16'hFFFF, 1'b0, '0);
      bus.inc_valid = 1'b1; bus.inc_addr = 2'd1;
      cycle();
      bus.inc_valid = 1'b0;
      rd(2'd0, 2'd1);
      chk("inc_wrap", bus.rd_data_b, 16'h0000);
      bus.inc_valid = 1'b1;
      cycle();
      cycle();
      bus.inc_valid = 1'b0;
      rd(2'd0, 2'd1);
      chk("inc_twice", bus.rd_data_b, 16'h0002);

      // Commit vs increment on the same edge
      wr(2'd0, 16'h00AA, 1'b1, 2'd0);
      chk("drop_same", obs_drop, 1'b1);
      rd(2'd0, 2'd0);
      chk("commit_wins", bus.rd_data_a, 16'h00AA);
      wr(2'd2, 16'h0100, 1'b0, '0);
      wr(2'd0, 16'h0011, 1'b1, 2'd2);
      chk("drop_diff", obs_drop, 1'b0);
      rd(2'd0, 2'd2);
      chk("both_commit", bus.rd_data_a, 16'h0011);
      chk("both_inc", bus.rd_data_b, 16'h0101);

      // clr_all in the middle of a write
      bus.wr_valid = 1'b1; bus.wr_addr = 2'd1; bus.wr_byte = 8'h55;
      cycle();
      bus.clr_all = 1'b1; bus.wr_byte = 8'h66;
      cycle();
      chk("clr_ready", obs_ready, 1'b0);
      chk("clr_no_done", obs_done, 1'b0);
      bus.clr_all = 1'b0; bus.wr_valid = 1'b0;
      cycle();
      chk("clr_no_done2", obs_done, 1'b0);
      for (int i = 0; i < N; i++) begin
         rd(AW'(i), AW'(i));
         chk("clr_rd", bus.rd_data_a, RV);
      end
      wr(2'd1, 16'hBEEF, 1'b0, '0);
      rd(2'd1, 2'd3);
      chk("after_clr_wr", bus.rd_data_a, 16'hBEEF);
      chk("oob_rd", bus.rd_data_b, 16'h0000);

      // Randomized traffic against the reference
      for (int c = 0; c < 1500; c++) begin
         bus.wr_valid  = ($urandom_range(0, 3) != 0);
         bus.wr_addr   = AW'($urandom_range(0, 3));
         bus.wr_byte   = 8'($urandom);
         bus.inc_valid = ($urandom_range(0, 2) == 0);
         bus.inc_addr  = AW'($urandom_range(0, 3));
         bus.clr_all   = ($urandom_range(0, 40) == 0);
         rst           = ($urandom_range(0, 200) == 0);
         bus.rd_addr_a = AW'($urandom_range(0, 3));
         bus.rd_addr_b = AW'($urandom_range(0, 3));
         cycle();
      end
      rst = 1'b0; bus.wr_valid = 1'b0; bus.inc_valid = 1'b0; bus.clr_all = 1'b0;
      repeat (3) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
